clkmgra_lock_ctrl: RTL and testbench

Reset and lock sequencer for the board clock managers (DCM/MMCM wrappers with an active-high RST input and a LOCKED output). It runs on a free-running reference clock, not on any clock-manager output. It pulses the manager reset, waits for and debounces LOCKED, and holds the downstream logic in reset until the clocks are stable. On lock loss it re-sequences, and after repeated lock failures it stops in a fail state.

---
 rtl/clkmgra_lock_ctrl_pkg.sv | 24 ++
 rtl/clkmgra_sync2.sv | 25 ++
 rtl/clkmgra_lock_ctrl.sv | 140 ++++++++++++++
 tb/tb_clkmgra_lock_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkmgra_lock_ctrl_pkg.sv
// Shared definitions for the clock-manager reset/lock sequencer: state
// encodings and the sizing rule for the shared down-counter.
package clkmgra_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    // The counter is loaded with (cycles - 1), so clog2 of the largest
    // window is enough bits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clkmgra_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to 0, for
// asynchronous status inputs such as a clock manager's LOCKED.
module clkmgra_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clkmgra_lock_ctrl.sv
// Reset and lock sequencer for a DCM/MMCM wrapper: pulses the manager reset,
// debounces LOCKED, and holds downstream logic in reset until clocks are stable.
module clkmgra_lock_ctrl
    import clkmgra_lock_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic       RESTART,
    output logic       MGR_RST,
    input  logic       MGR_LOCKED,
    output logic       DOWN_RST_N,
    output logic       CLK_READY,
    output logic       FAIL,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT,
    output logic [2:0] STATE
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] LD_RST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LD_WAIT   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] LD_STABLE = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d, retry_inc;
    logic [7:0]    loss_q, loss_d;
    logic          mgr_rst_q, down_rst_n_q, clk_ready_q, fail_q;
    logic          locked_s;
    state_e        fail_tgt;

    clkmgra_sync2 u_lock_sync (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .d_i    (MGR_LOCKED),
        .q_o    (locked_s)
    );

    // ENABLE is a level with top priority; RESTART is a one-cycle pulse
    // that is only acted on in FAIL.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = retry_q + 4'd1;
        fail_tgt  = ((MAX_RETRY != 0) && (retry_inc == RETRY_MAX)) ? ST_FAIL : ST_RESET;

        if (!ENABLE) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_RESET;
                ST_RESET:     if (cnt_q == '0) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == '0) begin
                        retry_d = retry_inc;
                        state_d = fail_tgt;
                    end
                end
                ST_STABLE: begin
                    // A dropout on the final counted cycle still fails the attempt.
                    if (!locked_s) begin
                        retry_d = retry_inc;
                        state_d = fail_tgt;
                    end else if (cnt_q == '0) begin
                        retry_d = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_RESET;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end
                end
                ST_FAIL: begin
                    if (RESTART) begin
                        retry_d = '0;
                        state_d = ST_RESET;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d != state_q) begin
            case (state_d)
                ST_RESET:     cnt_d = LD_RST;
                ST_WAIT_LOCK: cnt_d = LD_WAIT;
                ST_STABLE:    cnt_d = LD_STABLE;
                default:      cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Outputs are decoded from the next state so they move with STATE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            mgr_rst_q    <= 1'b1;
            down_rst_n_q <= 1'b0;
            clk_ready_q  <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            mgr_rst_q    <= (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
            down_rst_n_q <= (state_d == ST_RUN);
            clk_ready_q  <= (state_d == ST_RUN);
            fail_q       <= (state_d == ST_FAIL);
        end
    end

    assign MGR_RST    = mgr_rst_q;
    assign DOWN_RST_N = down_rst_n_q;
    assign CLK_READY  = clk_ready_q;
    assign FAIL       = fail_q;
    assign RETRY_CNT  = retry_q;
    assign LOSS_CNT   = loss_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_clkmgra_lock_ctrl.sv
// Directed bench for clkmgra_lock_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, MAX_RETRY=2; expected values are hand-derived cycle counts.
module tb_clkmgra_lock_ctrl;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STABLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       restart;
    logic       mgr_rst;
    logic       locked;
    logic       down_rst_n;
    logic       clk_ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    clkmgra_lock_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .ENABLE     (enable),
        .RESTART    (restart),
        .MGR_RST    (mgr_rst),
        .MGR_LOCKED (locked),
        .DOWN_RST_N (down_rst_n),
        .CLK_READY  (clk_ready),
        .FAIL       (fail),
        .RETRY_CNT  (retry_cnt),
        .LOSS_CNT   (loss_cnt),
        .STATE      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (state !== st && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        assert (state === st) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h after %0d cycles", tag, state, st, n);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mgr_rst"},    32'(mgr_rst),    32'd1);
        chk({tag, "_down_rst_n"}, 32'(down_rst_n), 32'd0);
        chk({tag, "_clk_ready"},  32'(clk_ready),  32'd0);
        chk({tag, "_fail"},       32'(fail),       32'd0);
        chk({tag, "_retry"},      32'(retry_cnt),  32'd0);
        chk({tag, "_loss"},       32'(loss_cnt),   32'd0);
        chk({tag, "_state"},      32'(state),      32'(S_IDLE));
    endtask

    initial begin
        int n;
        logic seen_up;

        rst_n   = 1'b0;
        enable  = 1'b0;
        restart = 1'b0;
        locked  = 1'b0;
        tick(3);
        chk_reset_vals("por");
        rst_n = 1'b1;
        tick(2);
        chk("idle_hold", 32'(state), 32'(S_IDLE));

        // Nominal bring-up
        enable = 1'b1;
        tick(1);
        chk("nom_reset_entry", 32'(state), 32'(S_RESET));
        chk("nom_mgr_rst_hi", 32'(mgr_rst), 32'd1);
        n = 0;
        while (mgr_rst === 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("nom_rst_len", 32'(n), 32'd4);
        chk("nom_wait_entry", 32'(state), 32'(S_WAIT));
        tick(20);
        chk("nom_still_wait", 32'(state), 32'(S_WAIT));
        locked = 1'b1;
        tick(2);
        chk("nom_sync_lat", 32'(state), 32'(S_WAIT));
        tick(1);
        chk("nom_stable", 32'(state), 32'(S_STABLE));
        tick(7);
        chk("nom_stable_end", 32'(state), 32'(S_STABLE));
        chk("nom_down_lo", 32'(down_rst_n), 32'd0);
        tick(1);
        chk("nom_run", 32'(state), 32'(S_RUN));
        chk("nom_down_hi", 32'(down_rst_n), 32'd1);
        chk("nom_ready", 32'(clk_ready), 32'd1);
        chk("nom_retry", 32'(retry_cnt), 32'd0);
        chk("nom_mgr_rst_lo", 32'(mgr_rst), 32'd0);

        // Lock loss in RUN, 5-cycle dropout
        locked = 1'b0;
        tick(2);
        chk("loss_down_still_hi", 32'(down_rst_n), 32'd1);
        tick(1);
        chk("loss_down_lo", 32'(down_rst_n), 32'd0);
        chk("loss_state", 32'(state), 32'(S_RESET));
        chk("loss_cnt1", 32'(loss_cnt), 32'd1);
        chk("loss_mgr_rst", 32'(mgr_rst), 32'd1);
        chk("loss_retry", 32'(retry_cnt), 32'd0);
        tick(2);
        locked = 1'b1;
        tick(1);
        chk("loss_rst_last", 32'(state), 32'(S_RESET));
        tick(1);
        chk("loss_wait", 32'(state), 32'(S_WAIT));
        chk("loss_mgr_rst_lo", 32'(mgr_rst), 32'd0);
        tick(1);
        chk("loss_stable", 32'(state), 32'(S_STABLE));
        tick(8);
        chk("loss_rerun", 32'(state), 32'(S_RUN));
        chk("loss_ready", 32'(clk_ready), 32'd1);

        // Flicker in STABLE
        locked = 1'b0;
        tick(3);
        chk("flk_reset", 32'(state), 32'(S_RESET));
        chk("flk_loss2", 32'(loss_cnt), 32'd2);
        locked = 1'b1;
        tick(5);
        chk("flk_stable", 32'(state), 32'(S_STABLE));
        tick(2);
        locked = 1'b0;
        tick(2);
        chk("flk_stable_hold", 32'(state), 32'(S_STABLE));
        locked = 1'b1;
        tick(1);
        chk("flk_back_reset", 32'(state), 32'(S_RESET));
        chk("flk_retry1", 32'(retry_cnt), 32'd1);
        seen_up = down_rst_n;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen_up = seen_up | down_rst_n;
        end
        chk("flk_down_never_up", 32'(seen_up), 32'd0);
        chk("flk_restable", 32'(state), 32'(S_STABLE));
        chk("flk_retry_hold", 32'(retry_cnt), 32'd1);
        tick(1);
        chk("flk_run", 32'(state), 32'(S_RUN));
        chk("flk_retry_clr", 32'(retry_cnt), 32'd0);

        // Lock timeout to FAIL
        locked = 1'b0;
        tick(3);
        chk("to_reset", 32'(state), 32'(S_RESET));
        chk("to_loss3", 32'(loss_cnt), 32'd3);
        tick(4);
        chk("to_wait1", 32'(state), 32'(S_WAIT));
        tick(31);
        chk("to_wait1_end", 32'(state), 32'(S_WAIT));
        chk("to_retry0", 32'(retry_cnt), 32'd0);
        tick(1);
        chk("to_reset2", 32'(state), 32'(S_RESET));
        chk("to_retry1", 32'(retry_cnt), 32'd1);
        chk("to_mgr_rst2", 32'(mgr_rst), 32'd1);
        tick(4);
        chk("to_wait2", 32'(state), 32'(S_WAIT));
        tick(31);
        chk("to_wait2_end", 32'(state), 32'(S_WAIT));
        tick(1);
        chk("to_fail", 32'(state), 32'(S_FAIL));
        chk("to_retry2", 32'(retry_cnt), 32'd2);
        chk("to_fail_out", 32'(fail), 32'd1);
        chk("to_fail_mgr_rst", 32'(mgr_rst), 32'd1);
        chk("to_fail_down", 32'(down_rst_n), 32'd0);
        chk("to_fail_ready", 32'(clk_ready), 32'd0);
        tick(3);
        chk("to_fail_sticky", 32'(state), 32'(S_FAIL));
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("rs_state", 32'(state), 32'(S_RESET));
        chk("rs_retry", 32'(retry_cnt), 32'd0);
        chk("rs_fail_lo", 32'(fail), 32'd0);

        // ENABLE=0 beats RESTART in FAIL
        wait_state("refail", S_FAIL, 100);
        chk("refail_retry", 32'(retry_cnt), 32'd2);
        enable  = 1'b0;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("prio_state", 32'(state), 32'(S_IDLE));
        chk("prio_retry", 32'(retry_cnt), 32'd0);
        chk("prio_mgr_rst", 32'(mgr_rst), 32'd1);
        chk("prio_fail", 32'(fail), 32'd0);

        // Asynchronous reset while in RUN
        enable = 1'b1;
        locked = 1'b1;
        wait_state("ar_run", S_RUN, 60);
        chk("ar_loss_pre", 32'(loss_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        tick(1);
        rst_n = 1'b1;

        // LOSS_CNT saturation
        for (int i = 0; i < 260; i++) begin
            wait_state("sat_run", S_RUN, 60);
            locked = 1'b0;
            wait_state("sat_rst", S_RESET, 10);
            locked = 1'b1;
            if (i == 253) chk("sat_254", 32'(loss_cnt), 32'd254);
            if (i == 254) chk("sat_255", 32'(loss_cnt), 32'd255);
        end
        wait_state("sat_final_run", S_RUN, 60);
        chk("sat_final", 32'(loss_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
